rope_node_renderer: RTL and testbench
=====================================

Name: rope_node_renderer

Overview:
- Parametrised successor to the rope-drawing pixel generator.
- Sequences the per-frame rope physics update with a clock-enable pulse train; no gated clock.
- Snapshots N node positions into shadow registers once per frame, giving tear-free drawing.
- Renders each node as a filled disc or a ring through a 2-stage registered pixel pipeline. Sits between the rope solver and the VGA sync/output stage.

Parameters:
- N_NODES, 20, number of rope nodes
- COORD_W, 10, coordinate width (pixels)
- RADIUS, 10, disc radius in pixels
- RING_W, 2, ring thickness in pixels for ring mode (RING_W <= RADIUS)
- STEPS_PER_FRAME, 7, solver step_en cycles issued per frame (>= 1)
- HEAD_COLOR, 3'b100, colour of node 0
- CIRCLE_COLOR, 3'b101, colour of all other nodes
- BG_COLOR, 3'b010, background colour

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- vsync  in  1  VGA vsync, synchronous to clk
- video_on  in  1  visible-area flag for pix_x/pix_y
- pix_x  in  COORD_W  current pixel column
- pix_y  in  COORD_W  current pixel row
- ring_mode  in  1  0 = filled disc, 1 = ring; sampled only at LATCH
- nodes_x  in  N_NODES*COORD_W  solver node x positions, node i at [i*COORD_W +: COORD_W]
- nodes_y  in  N_NODES*COORD_W  solver node y positions, same packing
- step_en  out  1  solver clock enable, one step per high cycle
- sim_init  out  1  solver initialise request
- overrun  out  1  sticky: a vsync fall arrived while not IDLE
- graph_rgb  out  3  pixel colour, 2-cycle latency

Behaviour:
- Reset (reset == 0 at a clk edge) sets:
  - state IDLE; step_en = 0; sim_init = 1; overrun = 0;
  - shadow_valid = 0; shadow regs = 0; ring_q = 0; graph_rgb = 3'b000;
  - all pipeline registers = 0; vsync_d = 1.
- Frame trigger: fall = vsync_d & ~vsync, where vsync_d is the registered vsync.
- FSM:
  - IDLE: on fall, go to STEP, cnt = 0.
  - STEP: step_en = 1 every cycle; cnt increments. When cnt == STEPS_PER_FRAME-1, go to SETTLE. step_en is high for exactly STEPS_PER_FRAME consecutive cycles.
  - SETTLE: one cycle, step_en = 0, for the solver output register delay. Then LATCH.
  - LATCH: one cycle. Shadow x/y <= nodes_x/nodes_y; ring_q <= ring_mode; shadow_valid <= 1. Then IDLE.
- sim_init clears on the first STEP cycle and stays 0 until the next reset. The solver treats step_en with sim_init = 1 as an initialise step.
- A fall in STEP, SETTLE or LATCH is ignored (no restart, no queueing) and sets overrun. overrun clears only on reset.
- Pixel pipeline (all stages always run; independent of FSM):
  - S1 registers pix_x, pix_y, video_on. Per node: dx = {0,sx} - {0,px} and dy likewise, signed COORD_W+1 bits.
  - S2 per node:
    - d2 = dx*dx + dy*dy, unsigned 2*COORD_W+3 bits, no truncation.
    - Disc hit: d2 <= RADIUS^2.
    - Ring hit: (RADIUS-RING_W)^2 < d2 <= RADIUS^2. RING_W == RADIUS gives a full disc minus its centre point.
  - Output register:
    - delayed video_on == 0 -> 3'b000
    - else !shadow_valid -> BG_COLOR
    - else node 0 hit -> HEAD_COLOR
    - else any hit -> CIRCLE_COLOR
    - else BG_COLOR
  - Pixel sampled at edge t appears on graph_rgb after edge t+2.
- A LATCH during active video updates the shadow regs mid-frame. This is legal, but the system places vsync so that LATCH falls in blanking.
- Reset asserted mid-STEP: step_en drops on the reset edge and the FSM restarts in IDLE.
- Coordinates near 0 or 2^COORD_W-1 must not alias. Node (0,0) with pixel (1023,0) gives dx = -1023 and is not a hit.

Test Plan:
- Reset low 3 cycles, release, no vsync -> step_en = 0, sim_init = 1, overrun = 0; graph_rgb = BG_COLOR (3'b010) when video_on = 1, 3'b000 when video_on = 0.
- vsync 1 -> 0 -> step_en high exactly 7 consecutive cycles starting 2 edges after the fall; sim_init drops with the first; shadow regs update 2 cycles after the last step_en.
- Node 0 at (100,100), others at (400,300), after LATCH, filled mode:
  - pixel (110,100) -> HEAD_COLOR 3'b100
  - pixel (111,100) -> BG_COLOR
  - pixel (407,307) -> CIRCLE_COLOR (d2 = 98)
  - each result appears 2 cycles after presentation.
- Ring mode with ring_mode = 1 at LATCH, RADIUS = 10, RING_W = 2:
  - pixel (100,100) -> BG
  - pixel (108,100) -> BG (d2 = 64)
  - pixel (109,100) -> HEAD (d2 = 81)
  - pixel (110,100) -> HEAD
- Wrap check: node at (0,0), pixel (1023,1023) -> BG. Node at (1020,5), pixel (1023,5) -> CIRCLE_COLOR.
- Second vsync fall during STEP -> overrun = 1, step_en still exactly 7 cycles total; reset low mid-STEP -> step_en = 0 on next edge, FSM IDLE, overrun = 0.

Source files
------------

// File: rtl/rope_node_renderer.sv
// Rope renderer: paces the solver with step_en pulses each frame and snapshots node positions once per frame.
// It draws each node as a disc or ring through a 2-register pixel pipeline (graph_rgb lags pix_x/pix_y by 2 cycles).
module rope_node_renderer #(
    parameter int             N_NODES         = 20,
    parameter int             COORD_W         = 10,
    parameter int             RADIUS          = 10,
    parameter int             RING_W          = 2,
    parameter int             STEPS_PER_FRAME = 7,
    parameter logic [2:0]     HEAD_COLOR      = 3'b100,
    parameter logic [2:0]     CIRCLE_COLOR    = 3'b101,
    parameter logic [2:0]     BG_COLOR        = 3'b010
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vsync,
    input  logic                         video_on,
    input  logic [COORD_W-1:0]           pix_x,
    input  logic [COORD_W-1:0]           pix_y,
    input  logic                         ring_mode,
    input  logic [N_NODES*COORD_W-1:0]   nodes_x,
    input  logic [N_NODES*COORD_W-1:0]   nodes_y,
    output logic                         step_en,
    output logic                         sim_init,
    output logic                         overrun,
    output logic [2:0]                   graph_rgb
);

    localparam int D2_W  = 2*COORD_W + 3;
    localparam int CNT_W = (STEPS_PER_FRAME > 1) ? $clog2(STEPS_PER_FRAME) : 1;
    localparam logic [D2_W-1:0] R2   = D2_W'(RADIUS*RADIUS);
    localparam logic [D2_W-1:0] RIN2 = D2_W'((RADIUS-RING_W)*(RADIUS-RING_W));

    typedef enum logic [1:0] {IDLE, STEP, SETTLE, LATCH} state_t;

    state_t                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         step_en_q;
    logic                         sim_init_q;
    logic                         overrun_q;
    logic                         vsync_q;
    logic                         fall;
    logic                         shadow_valid_q;
    logic                         ring_q;
    logic [N_NODES*COORD_W-1:0]   shadow_x_q;
    logic [N_NODES*COORD_W-1:0]   shadow_y_q;

    logic signed [COORD_W:0]      dx_q [N_NODES];
    logic signed [COORD_W:0]      dy_q [N_NODES];
    logic                         von_q;
    logic [2:0]                   rgb_q;
    logic [2:0]                   rgb_d;
    logic [N_NODES-1:0]           hit;

    assign fall = vsync_q & ~vsync;

    // step_en is registered from the STEP state, so it trails the state by one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            step_en_q      <= 1'b0;
            sim_init_q     <= 1'b1;
            overrun_q      <= 1'b0;
            vsync_q        <= 1'b1;
            shadow_valid_q <= 1'b0;
            ring_q         <= 1'b0;
            shadow_x_q     <= '0;
            shadow_y_q     <= '0;
        end else begin
            vsync_q <= vsync;
            if (fall && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    step_en_q <= 1'b0;
                    if (fall) begin
                        state_q <= STEP;
                        cnt_q   <= '0;
                    end
                end
                STEP: begin
                    step_en_q  <= 1'b1;
                    sim_init_q <= 1'b0;
                    if (cnt_q == CNT_W'(STEPS_PER_FRAME-1))
                        state_q <= SETTLE;
                    else
                        cnt_q <= cnt_q + CNT_W'(1);
                end
                SETTLE: begin
                    step_en_q <= 1'b0;
                    state_q   <= LATCH;
                end
                LATCH: begin
                    step_en_q      <= 1'b0;
                    shadow_x_q     <= nodes_x;
                    shadow_y_q     <= nodes_y;
                    ring_q         <= ring_mode;
                    shadow_valid_q <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Zero-extend before subtracting so edge coordinates never alias
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_NODES; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
            von_q <= 1'b0;
            rgb_q <= 3'b000;
        end else begin
            for (int i = 0; i < N_NODES; i++) begin
                dx_q[i] <= {1'b0, shadow_x_q[i*COORD_W +: COORD_W]} - {1'b0, pix_x};
                dy_q[i] <= {1'b0, shadow_y_q[i*COORD_W +: COORD_W]} - {1'b0, pix_y};
            end
            von_q <= video_on;
            rgb_q <= rgb_d;
        end
    end

    always_comb begin
        logic signed [D2_W-1:0] dxe;
        logic signed [D2_W-1:0] dye;
        logic [D2_W-1:0]        d2;
        hit = '0;
        dxe = '0;
        dye = '0;
        d2  = '0;
        for (int i = 0; i < N_NODES; i++) begin
            dxe = {{(D2_W-COORD_W-1){dx_q[i][COORD_W]}}, dx_q[i]};
            dye = {{(D2_W-COORD_W-1){dy_q[i][COORD_W]}}, dy_q[i]};
            d2  = D2_W'(dxe*dxe) + D2_W'(dye*dye);
            hit[i] = ring_q ? ((d2 > RIN2) && (d2 <= R2)) : (d2 <= R2);
        end
    end

    always_comb begin
        rgb_d = BG_COLOR;
        if (!von_q)
            rgb_d = 3'b000;
        else if (!shadow_valid_q)
            rgb_d = BG_COLOR;
        else if (hit[0])
            rgb_d = HEAD_COLOR;
        else if (|hit)
            rgb_d = CIRCLE_COLOR;
    end

    assign step_en   = step_en_q;
    assign sim_init  = sim_init_q;
    assign overrun   = overrun_q;
    assign graph_rgb = rgb_q;

endmodule

// File: tb/tb_rope_node_renderer.sv
// Directed bench for rope_node_renderer: frame sequencing, overrun, disc/ring hits and coordinate wrap.
module tb_rope_node_renderer;
    localparam int N = 20;
    localparam int W = 10;
    localparam logic [2:0] HEAD = 3'b100;
    localparam logic [2:0] CIRC = 3'b101;
    localparam logic [2:0] BG   = 3'b010;

    logic           clk = 1'b0;
    logic           reset;
    logic           vsync;
    logic           video_on;
    logic [W-1:0]   pix_x;
    logic [W-1:0]   pix_y;
    logic           ring_mode;
    logic [N*W-1:0] nodes_x;
    logic [N*W-1:0] nodes_y;
    logic           step_en;
    logic           sim_init;
    logic           overrun;
    logic [2:0]     graph_rgb;

    int n_tests = 0;
    int n_fail  = 0;

    rope_node_renderer dut (
        .clk(clk), .reset(reset), .vsync(vsync), .video_on(video_on),
        .pix_x(pix_x), .pix_y(pix_y), .ring_mode(ring_mode),
        .nodes_x(nodes_x), .nodes_y(nodes_y),
        .step_en(step_en), .sim_init(sim_init), .overrun(overrun),
        .graph_rgb(graph_rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nodes(input int x0, input int y0, input int x1, input int y1,
                             input int xr, input int yr);
        for (int i = 0; i < N; i++) begin
            nodes_x[i*W +: W] = W'(xr);
            nodes_y[i*W +: W] = W'(yr);
        end
        nodes_x[0 +: W] = W'(x0);
        nodes_y[0 +: W] = W'(y0);
        nodes_x[W +: W] = W'(x1);
        nodes_y[W +: W] = W'(y1);
    endtask

    task automatic do_frame(input logic ring);
        ring_mode = ring;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (12) tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic pixel(input string tag, input int x, input int y, input logic [2:0] exp);
        video_on = 1'b1;
        pix_x = W'(x);
        pix_y = W'(y);
        tick();
        tick();
        check(tag, {29'd0, graph_rgb}, {29'd0, exp});
    endtask

    initial begin
        logic [15:0] seen;
        int highs;
        reset = 1'b0; vsync = 1'b1; video_on = 1'b0;
        pix_x = '0; pix_y = '0; ring_mode = 1'b0;
        nodes_x = '0; nodes_y = '0;
        repeat (3) tick();
        check("rst_step_en", {31'd0, step_en}, 32'd0);
        check("rst_sim_init", {31'd0, sim_init}, 32'd1);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_rgb", {29'd0, graph_rgb}, 32'd0);
        reset = 1'b1;

        pixel("nofrm_bg", 500, 500, BG);
        video_on = 1'b0;
        tick(); tick();
        check("nofrm_blank", {29'd0, graph_rgb}, 32'd0);
        check("idle_step_en", {31'd0, step_en}, 32'd0);

        // First frame: watch step_en train and when the snapshot takes effect
        set_nodes(100, 100, 400, 300, 400, 300);
        video_on = 1'b1; pix_x = W'(110); pix_y = W'(100);
        vsync = 1'b0;
        seen = '0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            seen[i] = step_en;
            if (i == 1)  check("siminit_e1", {31'd0, sim_init}, 32'd1);
            if (i == 2)  check("siminit_e2", {31'd0, sim_init}, 32'd0);
            if (i == 11) check("rgb_e11", {29'd0, graph_rgb}, {29'd0, BG});
            if (i == 12) check("rgb_e12", {29'd0, graph_rgb}, {29'd0, HEAD});
        end
        check("step_train", {16'd0, seen}, 32'h0000_01FC);
        vsync = 1'b1;
        tick();

        pixel("fill_110", 110, 100, HEAD);
        pixel("fill_111", 111, 100, BG);
        pixel("fill_407", 407, 307, CIRC);
        pixel("fill_ctr", 100, 100, HEAD);
        pix_x = W'(111); pix_y = W'(100);
        tick();
        check("lat_1cyc", {29'd0, graph_rgb}, {29'd0, HEAD});
        tick();
        check("lat_2cyc", {29'd0, graph_rgb}, {29'd0, BG});

        video_on = 1'b0;
        do_frame(1'b1);
        pixel("ring_100", 100, 100, BG);
        pixel("ring_108", 108, 100, BG);
        pixel("ring_109", 109, 100, HEAD);
        pixel("ring_110", 110, 100, HEAD);

        video_on = 1'b0;
        set_nodes(0, 0, 1020, 5, 400, 300);
        do_frame(1'b0);
        pixel("wrap_corner", 1023, 1023, BG);
        pixel("wrap_edge", 1023, 5, CIRC);
        check("no_overrun", {31'd0, overrun}, 32'd0);

        // Second fall while stepping
        video_on = 1'b0;
        vsync = 1'b0;
        highs = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            highs += int'(step_en);
            if (i == 1) vsync = 1'b1;
            if (i == 2) vsync = 1'b0;
        end
        vsync = 1'b1;
        check("ovr_steps", highs, 32'd7);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        tick();

        // Reset in the middle of STEP
        vsync = 1'b0;
        tick(); tick(); tick();
        check("mid_step_hi", {31'd0, step_en}, 32'd1);
        reset = 1'b0;
        vsync = 1'b1;
        tick();
        check("mrst_step_en", {31'd0, step_en}, 32'd0);
        check("mrst_overrun", {31'd0, overrun}, 32'd0);
        check("mrst_siminit", {31'd0, sim_init}, 32'd1);
        reset = 1'b1;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            highs += int'(step_en);
        end
        check("mrst_idle", highs, 32'd0);
        pixel("mrst_bg", 100, 100, BG);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
